// File: rtl/fp_sqrt_stream_pkg.sv
// Shared types and constants for the fp_sqrt_stream adapter.
package fp_sqrt_stream_pkg;

  localparam int FP_W        = 32;
  localparam int DEF_LATENCY = 28;

  typedef enum logic {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fp_sqrt_stream_if.sv
// Request/response stream bundle for fp_sqrt_stream.
interface fp_sqrt_stream_if #(
  parameter int TAG_W = 4
);
  import fp_sqrt_stream_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [FP_W-1:0]  req_data;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [FP_W-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_data, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_data, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/fp_sqrt_stream_ring.sv
// Power-of-two circular buffer; head reads as zero while empty so outputs stay clean after reset.
module stream_ring
  import fp_sqrt_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          head,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full = (count == CW'(DEPTH));
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fp_sqrt_stream.sv
// Stream adapter around a fixed-latency FP sqrt unit with credit-based result buffering.
// Define FP_SQRT_STREAM_CHECK_EN to add the done-timing protocol checker that drives err.
module fp_sqrt_stream
  import fp_sqrt_stream_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  fp_sqrt_stream_if.slave bus,
  output logic            unit_go,
  output logic [FP_W-1:0] unit_operand,
  input  logic            unit_done,
  input  logic [FP_W-1:0] unit_result,
  output logic            err
);
  localparam int CW = cnt_w(DEPTH);
  localparam int DW = $clog2(LATENCY + 1);

  state_t           state;
  state_t           state_nx;
  logic [DW-1:0]    drain_cnt;
  logic [CW-1:0]    tag_count;
  logic [CW-1:0]    result_count;
  logic             tag_full;
  logic             result_full;
  logic             accept;
  logic             resp_pop;
  logic             result_push;
  logic [TAG_W-1:0] tag_head;
  logic [FP_W-1:0]  result_head;

  // tag_count covers in-flight work, so a credit here is a reserved result slot
  assign bus.req_ready  = !tag_full && (state == RUN);
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = (result_count != '0);
  assign resp_pop       = bus.resp_valid && bus.resp_ready;
  assign bus.resp_data  = result_head;
  assign bus.resp_tag   = bus.resp_valid ? tag_head : '0;

  // a done only counts when something is in flight and stale pipeline dones are ignored
  assign result_push = unit_done && (state == RUN) &&
                       (result_count != tag_count) && !result_full;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= DRAIN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == DRAIN && drain_cnt == '0) state_nx = RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                              drain_cnt <= DW'(LATENCY);
    else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
  end

  // Stage p0: launch into the sqrt unit
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      unit_go      <= 1'b0;
      unit_operand <= '0;
    end else begin
      unit_go <= accept;
      if (accept) unit_operand <= bus.req_data;
    end
  end

  stream_ring #(.WIDTH(TAG_W), .DEPTH(DEPTH)) u_tag_ring (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (resp_pop),
    .din     (bus.req_tag),
    .head    (tag_head),
    .count   (tag_count),
    .full    (tag_full)
  );

  stream_ring #(.WIDTH(FP_W), .DEPTH(DEPTH)) u_result_ring (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (result_push),
    .pop     (resp_pop),
    .din     (unit_result),
    .head    (result_head),
    .count   (result_count),
    .full    (result_full)
  );

`ifdef FP_SQRT_STREAM_CHECK_EN
  logic [LATENCY-1:0] expect_sr;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      expect_sr <= '0;
      err       <= 1'b0;
    end else begin
      expect_sr <= {expect_sr[LATENCY-2:0], unit_go};
      if (state == RUN && (unit_done != expect_sr[LATENCY-1])) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
